// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_unit_pkg
//   Shared types for the RV32M iterative divider.
//   - rv32_divop  : operation code issued by the divop decoder
//   - div_state_t : divider control states
//   - DIV_CYCLES  : number of restoring iterations (one per quotient bit)
//   - is_signed_op / is_rem_op : small decode helpers
// -----------------------------------------------------------------------------
package div_unit_pkg;

    typedef enum logic [2:0] {
        divop_nop  = 3'd0,
        divop_div  = 3'd1,
        divop_divu = 3'd2,
        divop_rem  = 3'd3,
        divop_remu = 3'd4
    } rv32_divop;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIN  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_t;

    localparam int DIV_CYCLES = 32;

    // div and rem interpret operands as two's complement
    function automatic logic is_signed_op(input rv32_divop op);
        return (op == divop_div) || (op == divop_rem);
    endfunction

    // rem and remu deliver the remainder instead of the quotient
    function automatic logic is_rem_op(input rv32_divop op);
        return (op == divop_rem) || (op == divop_remu);
    endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
//   One combinational restoring-division iteration.
//   Ports:
//     rem      in  32  partial remainder before this step
//     dvs      in  32  divisor (magnitude)
//     dvd_bit  in  1   next dividend bit, MSB first
//     rem_next out 32  partial remainder after this step
//     q_bit    out 1   quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step (
    input  logic [31:0] rem,
    input  logic [31:0] dvs,
    input  logic        dvd_bit,
    output logic [31:0] rem_next,
    output logic        q_bit
);

    logic [32:0] shifted;
    logic [31:0] diff;

    always_comb begin
        // The shifted remainder can reach 33 bits, so the compare is 33-bit.
        shifted  = {rem, dvd_bit};
        q_bit    = (shifted >= {1'b0, dvs});
        // When the subtraction is taken the true result is below dvs, so the
        // low 32 bits of the difference are exact.
        diff     = shifted[31:0] - dvs;
        rem_next = q_bit ? diff : shifted[31:0];
    end

endmodule

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//   Iterative radix-2 RV32M divider (div/divu/rem/remu). One operation in
//   flight; valid/ready handshake on request and result sides; destination
//   tag travels with the operation.
//   Ports:
//     i_clk    in   clock
//     i_rst    in   synchronous active-high reset (priority over i_flush)
//     i_flush  in   abort any in-flight or pending-result operation
//     i_valid  in   request valid
//     o_ready  out  unit idle; request accepted on i_valid && o_ready
//     i_divop  in   operation code
//     i_rs1    in   dividend
//     i_rs2    in   divisor
//     i_tag    in   destination tag
//     o_valid  out  result valid, held until i_ready
//     i_ready  in   consumer accepts result
//     o_result out  quotient or remainder
//     o_tag    out  tag of the result
//   Latency: special cases (divide by zero, signed overflow, nop) present the
//   result one cycle after accept; everything else after 34 cycles.
// -----------------------------------------------------------------------------
module div_unit
    import div_unit_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  rv32_divop        i_divop,
    input  logic [31:0]      i_rs1,
    input  logic [31:0]      i_rs2,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_result,
    output logic [TAG_W-1:0] o_tag
);

    div_state_t       state_reg;
    rv32_divop        op_reg;
    logic [TAG_W-1:0] tag_reg;
    logic [TAG_W-1:0] out_tag_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic [31:0]      dvd_reg;
    logic [31:0]      dvs_reg;
    logic [31:0]      quo_reg;
    logic [31:0]      rem_reg;
    logic [4:0]       cnt_reg;
    logic [31:0]      result_reg;
    logic             valid_reg;
    logic             ready_reg;

    // Request-side decode, only meaningful in the accept cycle
    logic             req_signed;
    logic [31:0]      req_abs1;
    logic [31:0]      req_abs2;
    logic             req_fast;
    logic [31:0]      req_fast_result;

    always_comb begin
        req_signed      = is_signed_op(i_divop);
        req_abs1        = (req_signed && i_rs1[31]) ? (32'd0 - i_rs1) : i_rs1;
        req_abs2        = (req_signed && i_rs2[31]) ? (32'd0 - i_rs2) : i_rs2;
        req_fast        = 1'b0;
        req_fast_result = 32'd0;
        if (i_divop == divop_nop) begin
            req_fast        = 1'b1;
            req_fast_result = 32'd0;
        end else if (i_rs2 == 32'd0) begin
            req_fast        = 1'b1;
            req_fast_result = is_rem_op(i_divop) ? i_rs1 : 32'hFFFF_FFFF;
        end else if (req_signed && (i_rs1 == 32'h8000_0000) && (i_rs2 == 32'hFFFF_FFFF)) begin
            req_fast        = 1'b1;
            req_fast_result = is_rem_op(i_divop) ? 32'd0 : 32'h8000_0000;
        end
    end

    logic [31:0] step_rem;
    logic        step_q;

    div_step u_step (
        .rem      (rem_reg),
        .dvs      (dvs_reg),
        .dvd_bit  (dvd_reg[cnt_reg]),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    // Sign fix-up applied on the unsigned magnitude results
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    always_comb begin
        quo_fix = neg_q_reg ? (32'd0 - quo_reg) : quo_reg;
        rem_fix = neg_r_reg ? (32'd0 - rem_reg) : rem_reg;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= DIV_IDLE;
            op_reg      <= divop_nop;
            tag_reg     <= '0;
            out_tag_reg <= '0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            dvd_reg     <= 32'd0;
            dvs_reg     <= 32'd0;
            quo_reg     <= 32'd0;
            rem_reg     <= 32'd0;
            cnt_reg     <= 5'd0;
            result_reg  <= 32'd0;
            valid_reg   <= 1'b0;
            ready_reg   <= 1'b1;
        end else if (i_flush) begin
            // Drop whatever is in flight; a request in this cycle is ignored.
            state_reg <= DIV_IDLE;
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
        end else begin
            case (state_reg)
                DIV_IDLE: begin
                    if (i_valid) begin
                        op_reg    <= i_divop;
                        tag_reg   <= i_tag;
                        neg_q_reg <= req_signed && (i_rs1[31] ^ i_rs2[31]);
                        neg_r_reg <= req_signed && i_rs1[31];
                        dvd_reg   <= req_abs1;
                        dvs_reg   <= req_abs2;
                        quo_reg   <= 32'd0;
                        rem_reg   <= 32'd0;
                        cnt_reg   <= 5'(DIV_CYCLES - 1);
                        ready_reg <= 1'b0;
                        if (req_fast) begin
                            state_reg   <= DIV_DONE;
                            result_reg  <= req_fast_result;
                            out_tag_reg <= i_tag;
                            valid_reg   <= 1'b1;
                        end else begin
                            state_reg <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    rem_reg          <= step_rem;
                    quo_reg[cnt_reg] <= step_q;
                    if (cnt_reg == 5'd0) begin
                        state_reg <= DIV_FIN;
                    end else begin
                        cnt_reg <= cnt_reg - 5'd1;
                    end
                end
                DIV_FIN: begin
                    result_reg  <= is_rem_op(op_reg) ? rem_fix : quo_fix;
                    out_tag_reg <= tag_reg;
                    valid_reg   <= 1'b1;
                    state_reg   <= DIV_DONE;
                end
                DIV_DONE: begin
                    if (i_ready) begin
                        valid_reg <= 1'b0;
                        ready_reg <= 1'b1;
                        state_reg <= DIV_IDLE;
                    end
                end
                default: begin
                    state_reg <= DIV_IDLE;
                    valid_reg <= 1'b0;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready  = ready_reg;
    assign o_valid  = valid_reg;
    assign o_result = result_reg;
    assign o_tag    = out_tag_reg;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
//   Self-checking bench for div_unit: directed RV32M cases, result hold,
//   flush and reset aborts, then randomized operations against a plain
//   arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_div_unit;
    import div_unit_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_flush;
    logic        i_valid;
    logic        o_ready;
    rv32_divop   i_divop;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic [4:0]  i_tag;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic [4:0]  o_tag;

    int n_checks = 0;
    int n_fail   = 0;

    div_unit #(.TAG_W(5)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_flush  (i_flush),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_divop  (i_divop),
        .i_rs1    (i_rs1),
        .i_rs2    (i_rs2),
        .i_tag    (i_tag),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_tag    (o_tag)
    );

    always #5 i_clk = ~i_clk;

    // RISC-V M-extension semantics expressed with plain integer arithmetic
    function automatic logic [31:0] model_result(input rv32_divop op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (op)
            divop_div:  begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            divop_rem:  begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            divop_divu: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            divop_remu: return (b == 0) ? a : a % b;
            default:    return 32'd0;
        endcase
    endfunction

    // Special cases finish one cycle after accept, the rest after 34
    function automatic int model_latency(input rv32_divop op, input logic [31:0] a, input logic [31:0] b);
        if (op == divop_nop || b == 0) return 1;
        if ((op == divop_div || op == divop_rem) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Issue one op, wait for result, hold it for 'hold' cycles, then consume it.
    task automatic run_op(input string name, input rv32_divop op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tg,
                          input logic [31:0] exp_res, input int exp_lat, input int hold);
        int lat;
        @(negedge i_clk);
        n_checks++;
        if (o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_before_issue: got %b want 1", name, o_ready);
        end
        i_valid = 1'b1; i_divop = op; i_rs1 = a; i_rs2 = b; i_tag = tg;
        @(negedge i_clk);
        i_valid = 1'b0;
        // operands changing after accept must not matter
        i_rs1 = $urandom; i_rs2 = $urandom; i_tag = 5'($urandom);
        lat = 1;
        while (o_valid !== 1'b1 && lat < 60) begin
            @(negedge i_clk);
            lat++;
        end
        n_checks++;
        if (o_valid !== 1'b1 || lat !== exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d (o_valid=%b) want %0d", name, lat, o_valid, exp_lat);
        end
        n_checks++;
        if (o_result !== exp_res || o_tag !== tg) begin
            n_fail++;
            $display("FAIL %s result: got %h tag %0d want %h tag %0d", name, o_result, o_tag, exp_res, tg);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge i_clk);
            n_checks++;
            if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_result !== exp_res || o_tag !== tg) begin
                n_fail++;
                $display("FAIL %s hold%0d: got v=%b r=%b %h tag %0d want v=1 r=0 %h tag %0d",
                         name, h, o_valid, o_ready, o_result, o_tag, exp_res, tg);
            end
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        n_checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s release: got v=%b r=%b want v=0 r=1", name, o_valid, o_ready);
        end
        $display("op %s %s a=%h b=%h -> %h tag %0d lat %0d", name, op.name(), a, b, o_result, o_tag, lat);
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_divop = divop_nop; i_rs1 = 0; i_rs2 = 0; i_tag = 0;
        repeat (3) @(negedge i_clk);
        n_checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_result !== 32'd0 || o_tag !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_state: got r=%b v=%b %h tag %0d want r=1 v=0 0 tag 0", o_ready, o_valid, o_result, o_tag);
        end
        i_rst = 1'b0;
        $display("reset r=%b v=%b res=%h tag=%0d", o_ready, o_valid, o_result, o_tag);
    endtask

    task automatic test_signed();
        run_op("div_20_m3",  divop_div, 32'd20, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFFA, 34, 0);
        run_op("rem_20_m3",  divop_rem, 32'd20, 32'hFFFF_FFFD, 5'd2, 32'd2,        34, 0);
        run_op("rem_m20_3",  divop_rem, 32'hFFFF_FFEC, 32'd3,  5'd3, 32'hFFFF_FFFE, 34, 0);
    endtask

    task automatic test_unsigned();
        run_op("divu_max_2", divop_divu, 32'hFFFF_FFFF, 32'd2, 5'd17, 32'h7FFF_FFFF, 34, 0);
        run_op("remu_max_2", divop_remu, 32'hFFFF_FFFF, 32'd2, 5'd17, 32'd1,         34, 0);
    endtask

    task automatic test_div_by_zero();
        run_op("div_7_0",  divop_div,  32'd7, 32'd0, 5'd4, 32'hFFFF_FFFF, 1, 0);
        run_op("divu_7_0", divop_divu, 32'd7, 32'd0, 5'd5, 32'hFFFF_FFFF, 1, 0);
        run_op("rem_7_0",  divop_rem,  32'd7, 32'd0, 5'd6, 32'd7,         1, 0);
        run_op("remu_7_0", divop_remu, 32'd7, 32'd0, 5'd7, 32'd7,         1, 0);
    endtask

    task automatic test_overflow();
        run_op("div_ovf",  divop_div,  32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'h8000_0000, 1,  0);
        run_op("rem_ovf",  divop_rem,  32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'd0,         1,  0);
        run_op("divu_ovf", divop_divu, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0,         34, 0);
        run_op("nop",      divop_nop,  32'd55, 32'd3,                5'd11, 32'd0,         1,  0);
    endtask

    task automatic test_hold();
        run_op("hold_div", divop_div, 32'd20, 32'hFFFF_FFFD, 5'd21, 32'hFFFF_FFFA, 34, 5);
    endtask

    // Starts an op and returns at the negedge inside cycle T+10
    task automatic start_and_wait10(input rv32_divop op, input logic [31:0] a, input logic [31:0] b);
        @(negedge i_clk);
        i_valid = 1'b1; i_divop = op; i_rs1 = a; i_rs2 = b; i_tag = 5'd30;
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (9) @(negedge i_clk);
    endtask

    task automatic test_flush();
        int seen;
        start_and_wait10(divop_div, 32'd1000, 32'd3);
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        n_checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_calc: got r=%b v=%b want r=1 v=0", o_ready, o_valid);
        end
        seen = 0;
        repeat (40) begin
            @(negedge i_clk);
            if (o_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL flush_no_result: got %0d valid cycles want 0", seen);
        end
        // request coinciding with a flush must be dropped
        i_flush = 1'b1; i_valid = 1'b1; i_divop = divop_divu; i_rs1 = 32'd9; i_rs2 = 32'd2;
        @(negedge i_clk);
        i_flush = 1'b0; i_valid = 1'b0;
        n_checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle_accept: got r=%b v=%b want r=1 v=0", o_ready, o_valid);
        end
        // flush while a result is waiting in DONE
        i_valid = 1'b1; i_divop = divop_div; i_rs1 = 32'd5; i_rs2 = 32'd0;
        @(negedge i_clk);
        i_valid = 1'b0;
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        n_checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_done: got r=%b v=%b want r=1 v=0", o_ready, o_valid);
        end
        $display("flush r=%b v=%b", o_ready, o_valid);
    endtask

    task automatic test_midop_reset();
        start_and_wait10(divop_rem, 32'd12345, 32'd77);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        n_checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_result !== 32'd0 || o_tag !== 5'd0) begin
            n_fail++;
            $display("FAIL midop_reset: got r=%b v=%b %h tag %0d want r=1 v=0 0 tag 0", o_ready, o_valid, o_result, o_tag);
        end
        run_op("div_100_7", divop_div, 32'd100, 32'd7, 5'd12, 32'd14, 34, 0);
    endtask

    task automatic test_random();
        rv32_divop   op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 150; i++) begin
            op = rv32_divop'($urandom_range(0, 4));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: b = 32'd0 - 32'($urandom_range(1, 15));
                4: a = 32'($urandom_range(0, 100));
                default: ;
            endcase
            run_op("rand", op, a, b, 5'($urandom), model_result(op, a, b),
                   model_latency(op, a, b), $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_signed();
        test_unsigned();
        test_div_by_zero();
        test_overflow();
        test_hold();
        test_flush();
        test_midop_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
